// File: rtl/tx_fifo_feeder.sv
// Byte FIFO plus send sequencer ahead of tx_serial; 2 clocks push-to-send through an empty FIFO.
// One send per byte, held off while tx_busy; pushes into a full FIFO are dropped and flagged.
module tx_fifo_feeder #(
  parameter int AW       = 4,
  parameter int BUSY_TMO = 7
) (
  input  logic        clk100,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        tx_busy,
  output logic        send,
  output logic [7:0]  sbyte,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  output logic        idle
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(BUSY_TMO + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAITB, S_WAITD} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [TW-1:0] tmo;
  logic          push;
  logic          pop;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign idle  = empty && (state == S_IDLE) && !tx_busy;

  // Flush wins over both ends: the pushed byte is discarded and nothing is issued from the old contents.
  assign push = wr_en && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && !tx_busy && !flush;

  always_ff @(posedge clk100) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (flush) begin
        overflow <= 1'b0;
      end else if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      send  <= 1'b0;
      sbyte <= 8'h00;
      tmo   <= '0;
    end else begin
      send <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            send  <= 1'b1;
            sbyte <= mem[rd_ptr[AW-1:0]];
            tmo   <= '0;
            state <= S_WAITB;
          end
        end
        S_WAITB: begin
          // A transmitter that never acknowledges must not stall the queue forever.
          if (tx_busy) begin
            state <= S_WAITD;
          end else if (tmo == TW'(BUSY_TMO)) begin
            state <= S_IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_WAITD: begin
          if (!tx_busy) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fifo_feeder.sv
// Randomised and directed bench for tx_fifo_feeder with a queue-based reference model.
module tb_tx_fifo_feeder;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 7;

  logic        clk100 = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        tx_busy;
  logic        send;
  logic [7:0]  sbyte;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        idle;

  tx_fifo_feeder #(.AW(AW), .BUSY_TMO(TMO)) dut (
    .clk100  (clk100),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .flush   (flush),
    .tx_busy (tx_busy),
    .send    (send),
    .sbyte   (sbyte),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .idle    (idle)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
    end
  endtask

  // Reference model: a byte queue plus "one byte in flight" bookkeeping.
  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         hs_on = 1'b0;
  bit         hs_seen = 1'b0;
  int         hs_start = 0;
  int         cyc = 0;
  bit         exp_send = 1'b0;
  logic [7:0] exp_sbyte = 8'h00;
  logic [7:0] out_q[$];
  int         send_cyc[$];
  bit         prev_send = 1'b0;

  always @(posedge clk100) begin
    bit was_full;
    bit do_pop;
    cyc++;
    if (!reset_n) begin
      mq.delete();
      m_ovf    = 1'b0;
      hs_on    = 1'b0;
      exp_send = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = !hs_on && (mq.size() > 0) && !tx_busy && !flush;
      // The in-flight byte is retired by a busy high-then-low, or by TMO+1 quiet edges after send.
      if (hs_on) begin
        if (hs_seen) begin
          if (!tx_busy) hs_on = 1'b0;
        end else if (tx_busy) begin
          hs_seen = 1'b1;
        end else if (cyc - hs_start == TMO + 1) begin
          hs_on = 1'b0;
        end
      end
      exp_send = do_pop;
      if (do_pop) begin
        exp_sbyte = mq.pop_front();
        hs_on     = 1'b1;
        hs_seen   = 1'b0;
        hs_start  = cyc;
      end
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else if (wr_en) begin
        if (was_full) m_ovf = 1'b1;
        else          mq.push_back(wr_data);
      end
    end
    #1;
    check("send", int'(send), int'(exp_send));
    if (exp_send && send) check("sbyte", int'(sbyte), int'(exp_sbyte));
    check("count", int'(count), mq.size());
    check("full", int'(full), int'(mq.size() == DEPTH));
    check("empty", int'(empty), int'(mq.size() == 0));
    check("overflow", int'(overflow), int'(m_ovf));
    check("idle", int'(idle), int'(mq.size() == 0 && !hs_on && !tx_busy));
    check("send_twice", int'(send && prev_send), 0);
    if (send) begin
      out_q.push_back(sbyte);
      send_cyc.push_back(cyc);
    end
    prev_send = send;
  end

  // Transmitter stand-in: 0 = reacts to send, 1 = busy tied low, 2 = busy held high.
  int tx_mode  = 0;
  int rise_cnt = 0;
  int hold     = 0;
  int busy_min = 20;
  int busy_max = 40;
  bit late_ok  = 1'b0;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk100);
      if (tx_mode == 1) begin
        tx_busy  = 1'b0;
        rise_cnt = 0;
      end else if (tx_mode == 2) begin
        tx_busy  = 1'b1;
        rise_cnt = 0;
        hold     = 0;
      end else begin
        if (rise_cnt > 0) begin
          rise_cnt--;
          if (rise_cnt == 0) begin
            tx_busy = 1'b1;
            hold    = int'($urandom_range(busy_min, busy_max));
          end
        end else if (tx_busy) begin
          if (hold == 0) tx_busy = 1'b0;
          else           hold--;
        end
        if (send && rise_cnt == 0 && !tx_busy) begin
          if (late_ok && $urandom_range(0, 7) == 0) rise_cnt = int'($urandom_range(8, 11));
          else                                      rise_cnt = int'($urandom_range(1, 4));
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk100);
    wr_en   = 1'b0;
  endtask

  task automatic wait_sends(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk100);
      k++;
    end
    check("sends_arrived", out_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(idle && mq.size() == 0 && rise_cnt == 0) && k < budget) begin
      @(negedge clk100);
      k++;
    end
    check("drained_idle", int'(idle), 1);
  endtask

  task automatic hold_busy();
    tx_mode = 2;
    repeat (2) @(negedge clk100);
  endtask

  initial begin
    int n0;
    int t0;
    int n1;
    int k;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    repeat (3) @(negedge clk100);
    check("rst_send", int'(send), 0);
    check("rst_sbyte", int'(sbyte), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clk100);

    // Single byte: send appears 2 clocks after the push cycle.
    n0 = out_q.size();
    t0 = cyc;
    push_byte(8'hA5);
    wait_sends(n0 + 1, 20);
    check("single_latency", send_cyc[n0] - t0, 2);
    check("single_byte", int'(out_q[n0]), 8'hA5);
    wait_idle(200);

    // Burst of 16 with the transmitter stalled, then drain in order.
    busy_min = 3;
    busy_max = 20;
    hold_busy();
    n0 = out_q.size();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("burst_full", int'(full), 1);
    check("burst_count", int'(count), 16);
    tx_mode = 0;
    wait_sends(n0 + 16, 16 * 60);
    for (int i = 0; i < 16; i++) check("burst_order", int'(out_q[n0 + i]), i);
    wait_idle(200);

    // Overflow: 17th byte is dropped and flagged; flush clears contents and flag.
    hold_busy();
    n0 = out_q.size();
    for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
    check("ovf_count", int'(count), 16);
    check("ovf_flag", int'(overflow), 1);
    tx_mode = 0;
    wait_sends(n0 + 16, 16 * 60);
    wait_idle(200);
    check("ovf_dropped", out_q.size(), n0 + 16);
    for (int i = 0; i < 16; i++) check("ovf_order", int'(out_q[n0 + i]), 8'h10 + i);
    check("ovf_sticky", int'(overflow), 1);
    hold_busy();
    for (int i = 0; i < 3; i++) push_byte(8'(8'hE0 + i));
    flush = 1'b1;
    @(negedge clk100);
    flush = 1'b0;
    check("flush_count", int'(count), 0);
    check("flush_ovf", int'(overflow), 0);
    tx_mode = 0;
    wait_idle(200);

    // Wrap-around: 30 bytes through the 16-entry buffer in three rounds.
    for (int r = 0; r < 3; r++) begin
      n0 = out_q.size();
      for (int i = 0; i < 10; i++) push_byte(8'(8'h40 + r * 10 + i));
      wait_sends(n0 + 10, 10 * 60);
      for (int i = 0; i < 10; i++) check("wrap_order", int'(out_q[n0 + i]), 8'h40 + r * 10 + i);
      wait_idle(200);
    end

    // Timeout: busy never rises, second send follows 9 clocks after the first.
    tx_mode = 1;
    repeat (2) @(negedge clk100);
    n0 = out_q.size();
    push_byte(8'h55);
    push_byte(8'h66);
    wait_sends(n0 + 2, 40);
    check("tmo_gap", send_cyc[n0 + 1] - send_cyc[n0], TMO + 2);
    check("tmo_first", int'(out_q[n0]), 8'h55);
    check("tmo_second", int'(out_q[n0 + 1]), 8'h66);
    wait_idle(40);

    // Reset while a frame is in flight with 5 bytes still queued.
    tx_mode  = 0;
    busy_min = 40;
    busy_max = 50;
    repeat (2) @(negedge clk100);
    for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i));
    k = 0;
    while (!tx_busy && k < 20) begin
      @(negedge clk100);
      k++;
    end
    @(negedge clk100);
    check("pre_rst_busy", int'(tx_busy), 1);
    check("pre_rst_count", int'(count), 5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_send", int'(send), 0);
    check("mid_rst_empty", int'(empty), 1);
    repeat (2) @(negedge clk100);
    reset_n = 1'b1;
    n1 = out_q.size();
    repeat (60) @(negedge clk100);
    check("post_rst_quiet", out_q.size(), n1);
    push_byte(8'h77);
    wait_sends(n1 + 1, 100);
    check("post_rst_byte", int'(out_q[n1]), 8'h77);
    wait_idle(200);

    // Random traffic against the model, with occasional flushes and transmitter mode changes.
    busy_min = 1;
    busy_max = 12;
    late_ok  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    tx_mode = 0;
          2:       tx_mode = 1;
          default: tx_mode = 2;
        endcase
      end
      wr_en   = ($urandom_range(0, 9) < 4);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 99) == 0);
      @(negedge clk100);
    end
    wr_en   = 1'b0;
    flush   = 1'b0;
    tx_mode = 0;
    wait_idle(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
